// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 input padder.
// Padding bytes, FSM encoding and the rate helper live here.
package sha3_pkg;

  localparam logic [7:0] SHA3_DOMAIN  = 8'h06;
  localparam logic [7:0] SHA3_PAD_END = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } sha3_state_t;

  function automatic int sha3_bitrate(input int outbits);
    return 1600 - 2 * outbits;
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Pads the final message word: keeps the valid MSB-first bytes,
// inserts the domain byte and clears everything below it.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [31:0] in,
  input  logic [1:0]  byte_num,
  input  logic        is_last,
  output logic [31:0] out
);

  always_comb begin
    out = in;
    if (is_last) begin
      for (int b = 0; b < 4; b++) begin
        if (b == int'(byte_num)) begin
          out[31-8*b -: 8] = SHA3_DOMAIN;
        end else if (b > int'(byte_num)) begin
          out[31-8*b -: 8] = 8'h00;
        end
      end
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// Collects 32-bit words into one rate-sized block, applies SHA-3
// padding on the last word and hands blocks over with valid/ack.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter int R_BITRATE = 576
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 soft_reset,
  input  logic [31:0]          in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [1:0]           byte_num,
  output logic                 buffer_full,
  output logic                 in_dropped,
  output logic [R_BITRATE-1:0] out,
  output logic                 out_valid,
  output logic                 out_last,
  input  logic                 out_ack
);

  localparam int NW = R_BITRATE / 32;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] TOP = CW'(NW - 1);

  sha3_state_t          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [R_BITRATE-1:0] blk_q, blk_d;
  logic                 last_q, last_d;
  logic                 drop_q, drop_d;
  logic [31:0]          pad_w;

  sha3_pad_word u_pad (
    .in       (in),
    .byte_num (byte_num),
    .is_last  (is_last),
    .out      (pad_w)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= FILL;
      cnt_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    last_d  = last_q;
    drop_d  = in_ready && (state_q != FILL);
    if (soft_reset) begin
      state_d = FILL;
      cnt_d   = '0;
      blk_d   = '0;
      last_d  = 1'b0;
      drop_d  = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_ready) begin
            for (int i = 0; i < NW; i++) begin
              if (i == int'(cnt_q)) begin
                blk_d[R_BITRATE-1-32*i -: 32] = pad_w;
              end else if (is_last && (i > int'(cnt_q))) begin
                blk_d[R_BITRATE-1-32*i -: 32] = 32'h0;
              end
            end
            // Final pad byte always lands in the lowest byte of the block
            if (is_last) begin
              blk_d[7:0] = blk_d[7:0] | SHA3_PAD_END;
              last_d     = 1'b1;
              state_d    = HOLD;
            end else if (cnt_q == TOP) begin
              state_d = HOLD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ack) begin
            if (last_q) begin
              state_d = DONE;
            end else begin
              state_d = FILL;
              blk_d   = '0;
              cnt_d   = '0;
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  assign out         = blk_q;
  assign out_valid   = (state_q == HOLD);
  assign out_last    = last_q;
  assign buffer_full = (state_q != FILL);
  assign in_dropped  = drop_q;

endmodule
